mul_div_unit: RTL and testbench

//  Iterative HI/LO multiply/divide unit for the MIPS datapath. Sits downstream of reg_file:

---
 rtl/mips_pkg.sv | 32 +++
 rtl/mul_div_unit.sv | 214 +++++++++++++++++++++
 tb/tb_mul_div_unit.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS datapath definitions used by the HI/LO multiply/divide unit.
package mips_pkg;

  // Multiply/divide operation select, encoded as driven by the decoder.
  typedef enum logic [1:0] {
    MD_MULT  = 2'd0,
    MD_MULTU = 2'd1,
    MD_DIV   = 2'd2,
    MD_DIVU  = 2'd3
  } md_op_t;

  // Iterative unit sequencing states.
  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_CALC = 2'd1,
    MD_FIX  = 2'd2
  } md_state_t;

  // Default operand width, which is also the number of CALC iterations.
  localparam int MD_ITERS = 32;

  // True for the two's-complement variants (MULT, DIV).
  function automatic logic md_is_signed(input md_op_t op);
    return (op == MD_MULT) || (op == MD_DIV);
  endfunction

  // True for the divide variants (DIV, DIVU).
  function automatic logic md_is_div(input md_op_t op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/mul_div_unit.sv
// Iterative HI/LO multiply/divide unit: one shift-add or restoring-subtract
// step per cycle on operand magnitudes, signs applied in a final FIX cycle.
module mul_div_unit
  import mips_pkg::*;
#(
  parameter int WIDTH = MD_ITERS
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  md_op_t           op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wd,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int AW = 2 * WIDTH;
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_ZERO = CW'(0);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  // Two's-complement negate of a WIDTH-bit value.
  function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] x);
    return ~x + {{(WIDTH-1){1'b0}}, 1'b1};
  endfunction

  // Two's-complement negate of a double-width value.
  function automatic logic [AW-1:0] neg_2w(input logic [AW-1:0] x);
    return ~x + {{(AW-1){1'b0}}, 1'b1};
  endfunction

  // Magnitude of an operand; unsigned ops pass sgn=0 so the value is kept.
  function automatic logic [WIDTH-1:0] abs_w(input logic [WIDTH-1:0] x, input logic sgn);
    return sgn ? neg_w(x) : x;
  endfunction

  // One multiply step: acc = {partial, multiplier}; add multiplicand into the
  // upper half when the multiplier LSB is set, then shift right with carry.
  function automatic logic [AW-1:0] mul_step(input logic [AW-1:0] acc,
                                             input logic [WIDTH-1:0] mcand);
    logic [WIDTH:0] sum;
    sum = {1'b0, acc[AW-1:WIDTH]} + {1'b0, (acc[0] ? mcand : {WIDTH{1'b0}})};
    return {sum, acc[WIDTH-1:1]};
  endfunction

  // One restoring divide step: acc = {remainder, dividend/quotient}; shift in
  // the next dividend bit and subtract the divisor if it fits.
  function automatic logic [AW-1:0] div_step(input logic [AW-1:0] acc,
                                             input logic [WIDTH-1:0] dvsr);
    logic [WIDTH:0] rem;
    logic [WIDTH:0] diff;
    rem  = {acc[AW-1:WIDTH], acc[WIDTH-1]};
    diff = rem - {1'b0, dvsr};
    if (!diff[WIDTH]) begin
      return {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
    end else begin
      return {rem[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
    end
  endfunction

  // Apply result signs. Divide by zero needs no special case: the magnitude
  // divide yields all-ones/|a|, and the sign rules turn that into 1/a for a<0.
  function automatic logic [AW-1:0] fix_result(input logic is_div, input logic neg_a,
                                               input logic neg_b, input logic [AW-1:0] acc);
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] rem;
    logic [AW-1:0]    prod;
    if (is_div) begin
      quo = (neg_a ^ neg_b) ? neg_w(acc[WIDTH-1:0]) : acc[WIDTH-1:0];
      rem = neg_a ? neg_w(acc[AW-1:WIDTH]) : acc[AW-1:WIDTH];
      return {rem, quo};
    end else begin
      prod = (neg_a ^ neg_b) ? neg_2w(acc) : acc;
      return prod;
    end
  endfunction

  md_state_t        state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  md_op_t           op_q, op_d;
  logic [WIDTH-1:0] opnd_q, opnd_d;     // multiplicand |a| or divisor |b|
  logic             neg_a_q, neg_a_d;
  logic             neg_b_q, neg_b_d;
  logic [AW-1:0]    acc_q, acc_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             done_q, done_d;
  logic             busy_q, busy_d;

  logic             start_signed_s;
  logic             start_neg_a_s;
  logic             start_neg_b_s;
  logic [WIDTH-1:0] start_abs_a_s;
  logic [WIDTH-1:0] start_abs_b_s;
  logic [AW-1:0]    fix_s;

  // Operand conditioning for a launch: sign flags and magnitudes.
  always_comb begin
    start_signed_s = md_is_signed(op);
    start_neg_a_s  = start_signed_s & src_a[WIDTH-1];
    start_neg_b_s  = start_signed_s & src_b[WIDTH-1];
    start_abs_a_s  = abs_w(src_a, start_neg_a_s);
    start_abs_b_s  = abs_w(src_b, start_neg_b_s);
    fix_s          = fix_result(md_is_div(op_q), neg_a_q, neg_b_q, acc_q);
  end

  // Next-state logic: IDLE accepts MT writes and launches, CALC iterates, FIX commits.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    opnd_d  = opnd_q;
    neg_a_d = neg_a_q;
    neg_b_d = neg_b_q;
    acc_d   = acc_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;
    case (state_q)
      MD_IDLE: begin
        if (hi_we) begin
          hi_d = wd;
        end else begin
          hi_d = hi_q;
        end
        if (lo_we) begin
          lo_d = wd;
        end else begin
          lo_d = lo_q;
        end
        if (start) begin
          op_d    = op;
          neg_a_d = start_neg_a_s;
          neg_b_d = start_neg_b_s;
          if (md_is_div(op)) begin
            opnd_d = start_abs_b_s;
            acc_d  = {{WIDTH{1'b0}}, start_abs_a_s};
          end else begin
            opnd_d = start_abs_a_s;
            acc_d  = {{WIDTH{1'b0}}, start_abs_b_s};
          end
          cnt_d   = CNT_LAST;
          state_d = MD_CALC;
        end else begin
          state_d = MD_IDLE;
        end
      end
      MD_CALC: begin
        if (md_is_div(op_q)) begin
          acc_d = div_step(acc_q, opnd_q);
        end else begin
          acc_d = mul_step(acc_q, opnd_q);
        end
        if (cnt_q == CNT_ZERO) begin
          state_d = MD_FIX;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      MD_FIX: begin
        hi_d    = fix_s[AW-1:WIDTH];
        lo_d    = fix_s[WIDTH-1:0];
        done_d  = 1'b1;
        state_d = MD_IDLE;
      end
      default: begin
        state_d = MD_IDLE;
      end
    endcase
    busy_d = (state_d != MD_IDLE);
  end

  // State and architectural HI/LO registers; reset clears everything, even mid-op.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= MD_IDLE;
      cnt_q   <= CNT_ZERO;
      op_q    <= MD_MULT;
      opnd_q  <= {WIDTH{1'b0}};
      neg_a_q <= 1'b0;
      neg_b_q <= 1'b0;
      acc_q   <= {AW{1'b0}};
      hi_q    <= {WIDTH{1'b0}};
      lo_q    <= {WIDTH{1'b0}};
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      opnd_q  <= opnd_d;
      neg_a_q <= neg_a_d;
      neg_b_q <= neg_b_d;
      acc_q   <= acc_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Scoreboard bench for mul_div_unit: drivers push expected HI/LO and launch
// edge; a negedge monitor pops and compares on every done pulse.
module tb_mul_div_unit;
  import mips_pkg::*;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  md_op_t       op;
  logic [W-1:0] src_a;
  logic [W-1:0] src_b;
  logic         hi_we;
  logic         lo_we;
  logic [W-1:0] wd;
  logic         busy;
  logic         done;
  logic [W-1:0] hi;
  logic [W-1:0] lo;

  mul_div_unit #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op),
    .src_a(src_a), .src_b(src_b), .hi_we(hi_we), .lo_we(lo_we), .wd(wd),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int done_cnt = 0;

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    int           e0;
    string        name;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  // Monitor: compare every done pulse against the oldest expectation.
  always @(negedge clk) begin
    if (reset === 1'b0) begin
      if (busy && done) begin
        checks++;
        failures++;
        $display("FAIL busy_done_overlap: busy=%0b done=%0b at cycle %0d", busy, done, cyc);
      end
      if (done) begin
        done_cnt++;
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_done: hi=0x%08h lo=0x%08h with empty scoreboard", hi, lo);
        end else begin
          mon_e = sb.pop_front();
          chk({mon_e.name, "_hi"}, hi, mon_e.hi);
          chk({mon_e.name, "_lo"}, lo, mon_e.lo);
          chk({mon_e.name, "_latency"}, W'(cyc - mon_e.e0), W'(33));
        end
      end
    end
  end

  // Launch one op at the next rising edge and record its expected result.
  task automatic issue(input md_op_t o, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] eh, input logic [W-1:0] el, input string nm);
    exp_t e;
    @(negedge clk);
    op = o; src_a = a; src_b = b; start = 1'b1;
    e.hi = eh; e.lo = el; e.e0 = cyc + 1; e.name = nm;
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0;
    src_a = ~a;
    src_b = ~b;
  endtask

  // Bounded wait for the unit to go idle with all expectations consumed.
  task automatic wait_idle(input string nm);
    int n;
    n = 0;
    @(negedge clk);
    while ((busy || sb.size() != 0) && n < 80) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (busy || sb.size() != 0) begin
      failures++;
      $display("FAIL timeout_%s: busy=%0b pending=%0d after %0d cycles", nm, busy, sb.size(), n);
    end
  endtask

  int d0;

  initial begin
    reset = 1'b1; start = 1'b0; op = MD_MULT; src_a = '0; src_b = '0;
    hi_we = 1'b0; lo_we = 1'b0; wd = '0;
    repeat (3) @(negedge clk);
    chk("reset_busy", W'(busy), W'(0));
    chk("reset_done", W'(done), W'(0));
    chk("reset_hi", hi, 32'h0);
    chk("reset_lo", lo, 32'h0);
    reset = 1'b0;

    issue(MD_MULTU, 32'hFFFFFFFF, 32'd2, 32'h00000001, 32'hFFFFFFFE, "multu_max_x2");
    chk("busy_after_start", W'(busy), W'(1));
    wait_idle("t1");
    issue(MD_MULT, 32'hFFFFFFFD, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFF1, "mult_m3x5");
    wait_idle("t2a");
    issue(MD_DIV, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, "div_m7d2");
    wait_idle("t2b");
    issue(MD_DIV, 32'd7, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, "div_7dm2");
    wait_idle("t2c");
    issue(MD_DIVU, 32'd7, 32'd0, 32'h00000007, 32'hFFFFFFFF, "divu_by0");
    wait_idle("t3a");
    issue(MD_DIV, 32'hFFFFFFF9, 32'd0, 32'hFFFFFFF9, 32'h00000001, "div_neg_by0");
    wait_idle("t3b");
    issue(MD_DIV, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, "div_min_dm1");
    wait_idle("t3c");
    issue(MD_MULT, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, "mult_min_sq");
    wait_idle("t3d");
    issue(MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, "multu_max_sq");
    wait_idle("t3e");
    issue(MD_DIVU, 32'hFFFFFFFF, 32'h00000010, 32'h0000000F, 32'h0FFFFFFF, "divu_big");
    wait_idle("t3f");

    // Start while busy is ignored: exactly one done, original operands.
    d0 = done_cnt;
    issue(MD_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, "divu_100d7");
    repeat (3) @(negedge clk);
    op = MD_MULT; src_a = 32'd50; src_b = 32'd5; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("busy_during_restart", W'(busy), W'(1));
    wait_idle("t4");
    repeat (4) @(negedge clk);
    chk("single_done_pulse", W'(done_cnt - d0), W'(1));

    // Asynchronous reset mid-op clears state without a clock edge.
    issue(MD_MULT, 32'd3, 32'd5, 32'd0, 32'd15, "mult_aborted");
    repeat (8) @(negedge clk);
    #1 reset = 1'b1;
    #1;
    chk("abort_busy", W'(busy), W'(0));
    chk("abort_done", W'(done), W'(0));
    chk("abort_hi", hi, 32'h0);
    chk("abort_lo", lo, 32'h0);
    sb.delete();
    @(negedge clk);
    reset = 1'b0;
    issue(MD_MULTU, 32'd6, 32'd7, 32'd0, 32'd42, "multu_6x7");
    wait_idle("t5");

    // MTHI/MTLO in IDLE, dropped while busy.
    @(negedge clk);
    hi_we = 1'b1; wd = 32'h00001234;
    @(negedge clk);
    hi_we = 1'b0;
    chk("mthi_idle", hi, 32'h00001234);
    lo_we = 1'b1; wd = 32'h00005678;
    @(negedge clk);
    lo_we = 1'b0;
    chk("mtlo_idle", lo, 32'h00005678);
    issue(MD_MULTU, 32'd3, 32'd4, 32'd0, 32'd12, "multu_3x4");
    lo_we = 1'b1; hi_we = 1'b1; wd = 32'hDEADBEEF;
    repeat (5) @(negedge clk);
    lo_we = 1'b0; hi_we = 1'b0;
    chk("mtlo_busy_dropped", lo, 32'h00005678);
    chk("mthi_busy_dropped", hi, 32'h00001234);
    wait_idle("t6");

    // MT write in the launch cycle lands, then the result overwrites it.
    @(negedge clk);
    op = MD_MULTU; src_a = 32'd2; src_b = 32'd3; start = 1'b1;
    hi_we = 1'b1; wd = 32'h0000ABCD;
    sb.push_back('{hi: 32'd0, lo: 32'd6, e0: cyc + 1, name: "multu_with_mthi"});
    @(negedge clk);
    start = 1'b0; hi_we = 1'b0;
    chk("mthi_same_cycle_as_start", hi, 32'h0000ABCD);
    wait_idle("t7");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
